mul_iter_ctrl: RTL

- Iterative shift-add multiplier sequencer for the `mul` library.
- Time-shares one WIDTH-bit ripple row of 1-bit full-adder cells across WIDTH cycles. This replaces a full array when area matters more than latency.
- Sits beside the EX stage: EX issues `start`, holds its pipeline on `busy`, and captures `result` on `ready`.
- Supports signed and unsigned operands. Signed operands are handled by a magnitude multiply followed by a sign fix-up.

---
 rtl/mul_pkg.sv | 17 +
 rtl/full_adder.sv | 16 +
 rtl/rca_row.sv | 27 ++
 rtl/mul_iter_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: default sizes and FSM encoding.
package mul_pkg;

    // Default operand width; the product is twice this.
    localparam int WIDTH_DEF = 32;

    // Default iteration counter width; 2**CNT_W_DEF must exceed WIDTH_DEF.
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/full_adder.sv
// 1-bit full-adder cell, the building block of the shared adder row.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain sum/majority equations.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/rca_row.sv
// WIDTH-bit ripple-carry adder row built as a chain of full-adder cells.
module rca_row #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/mul_iter_ctrl.sv
// Iterative shift-add multiplier sequencer: one shared adder row, WIDTH iterations,
// signed operands handled as magnitudes with a final two's-complement fix-up.
module mul_iter_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mul_signed,
    input  logic [WIDTH-1:0]   ina,
    input  logic [WIDTH-1:0]   inb,
    input  logic               cancel,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [2*WIDTH-1:0] PROD_ONE = (2*WIDTH)'(1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic             neg_q;
    logic [CNT_W-1:0] cnt_q;

    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] row_sum;
    logic             row_cout;
    logic [2*WIDTH-1:0] prod, prod_neg;

    // Operand magnitudes; -2**(WIDTH-1) maps to 2**(WIDTH-1), which fits unsigned.
    always_comb begin
        neg_a    = mul_signed & ina[WIDTH-1];
        neg_b    = mul_signed & inb[WIDTH-1];
        mag_a    = neg_a ? -ina : ina;
        mag_b    = neg_b ? -inb : inb;
        addend   = acc_lo_q[0] ? mcand_q : '0;
        prod     = {acc_hi_q, acc_lo_q};
        // Dedicated incrementer, independent of the shared row.
        prod_neg = ~prod + PROD_ONE;
    end

    rca_row #(
        .WIDTH (WIDTH)
    ) u_row (
        .a    (acc_hi_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (row_sum),
        .cout (row_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cancel overrides everything, including a same-cycle start.
    always_comb begin
        state_d = state_q;
        if (cancel) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = CALC;
                CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
                FIX:     state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy  = (state_q != IDLE);
        ready = (state_q == DONE);
    end

    // Datapath: operand capture, shift-add iterations and result write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !cancel) begin
                        mcand_q  <= mag_a;
                        acc_hi_q <= '0;
                        acc_lo_q <= mag_b;
                        neg_q    <= neg_a ^ neg_b;
                        cnt_q    <= '0;
                    end
                end
                CALC: begin
                    // {cout, sum, acc_lo} shifted right by one.
                    acc_hi_q <= {row_cout, row_sum[WIDTH-1:1]};
                    acc_lo_q <= {row_sum[0], acc_lo_q[WIDTH-1:1]};
                    cnt_q    <= cnt_q + CNT_ONE;
                end
                FIX: begin
                    if (!cancel) begin
                        result <= neg_q ? prod_neg : prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
